// File: rtl/relu_backward_stream_if.sv
// relu_backward_stream_if: start/status, input stream and output stream of the ReLU engine
// slave  : the engine (consumes starts, in_*, out_ready; drives status, in_ready, out_*)
// master : the upstream/downstream environment
interface relu_backward_stream_if #(
  parameter int BITWIDTH = 32
);
  logic                fwd_start;
  logic                bwd_start;
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] out_data;
  logic                out_last;
  logic                busy;
  logic                mask_valid;
  logic                proto_err;
  modport slave (
    input  fwd_start, bwd_start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, mask_valid, proto_err
  );
  modport master (
    output fwd_start, bwd_start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, mask_valid, proto_err
  );
endinterface

// File: rtl/relu_backward_stream.sv
// relu_backward_stream: streaming forward ReLU with stored kill mask, replayed on backward gradients
// clk, rst_n : clock, asynchronous active-low reset
// bus        : fwd/bwd start pulses, in valid/ready/data, out valid/ready/data/last, busy, mask_valid, proto_err
module relu_backward_stream #(
  parameter int BITWIDTH = 32,
  parameter int CHANNELS = 2,
  parameter int HEIGHT   = 28,
  parameter int WIDTH    = 28
) (
  input logic                  clk,
  input logic                  rst_n,
  relu_backward_stream_if.slave bus
);
  localparam int N  = CHANNELS * HEIGHT * WIDTH;
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, FWD, BWD} state_t;
  state_t              state_q, state_d;
  logic [IW-1:0]       index_q, index_d;
  logic                out_valid_q, out_valid_d;
  logic [BITWIDTH-1:0] out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                mask_valid_q, mask_valid_d;
  logic                proto_err_q, proto_err_d;
  logic [N-1:0]        mask_q;
  logic                in_ready, in_hs, last, kill;
  // The single output register may accept a new word when empty or draining this cycle.
  assign in_ready = (state_q != IDLE) && (!out_valid_q || bus.out_ready);
  assign in_hs    = bus.in_valid && in_ready;
  assign last     = index_q == IW'(N - 1);
  assign kill     = bus.in_data[BITWIDTH-1];
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.mask_valid = mask_valid_q;
  assign bus.proto_err  = proto_err_q;
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    mask_valid_d = mask_valid_q;
    proto_err_d  = 1'b0;
    out_valid_d  = in_hs || (out_valid_q && !bus.out_ready);
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    if (in_hs) begin
      out_data_d = (state_q == FWD) ? (kill ? '0 : bus.in_data)
                                    : (mask_q[index_q] ? bus.in_data : '0);
      out_last_d = last;
      index_d    = last ? '0 : index_q + IW'(1);
      state_d    = last ? IDLE : state_q;
      mask_valid_d = mask_valid_q || (last && state_q == FWD);
    end
    if (state_q == IDLE) begin
      if (bus.fwd_start) begin
        state_d      = FWD;
        index_d      = '0;
        mask_valid_d = 1'b0;
      end else if (bus.bwd_start) begin
        state_d     = mask_valid_q ? BWD : IDLE;
        index_d     = '0;
        proto_err_d = !mask_valid_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      index_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      mask_valid_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      mask_valid_q <= mask_valid_d;
      proto_err_q  <= proto_err_d;
    end
  end
  // Mask contents need no reset: mask_valid gates every use of them.
  always_ff @(posedge clk) begin
    if (in_hs && state_q == FWD) mask_q[index_q] <= !kill;
  end
endmodule
